load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle memory-access stage directly downstream of the ALU. It takes the effective address computed by the ALU for load/store instructions, performs one Avalon-MM bus transaction, and returns the aligned, extended or merged load result for register write-back. Byte-lane steering covers sub-word stores; LWL/LWR merging is supported.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a memory op; sampled only while busy=0
- op  in  7  internal opcode (cpu_pkg::opcode_internal); only load/store codes are legal
- addr  in  32  effective byte address (ALU result r)
- store_data  in  32  rt value for stores; store data is in the low bits
- rt_old  in  32  current rt value, used as the merge source for LWL/LWR
- busy  out  1  high from the cycle after accepted start until done cycle (exclusive)
- done  out  1  one-cycle pulse when the op completes
- load_data  out  32  write-back value; valid with done for loads, held until next load done
- addr_err  out  1  pulses with done on misaligned access (macro-dependent)
- address  out  32  Avalon word address {addr[31:2],2'b00}
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- byteenable  out  4  Avalon byte lanes; lane i = writedata/readdata[8i+7:8i]
- writedata  out  32  Avalon write data
- readdata  in  32  Avalon read data, valid in cycle where read=1 and waitrequest=0
- waitrequest  in  1  slave stall; master holds all bus outputs while high

## Operation
- Opcodes handled (values in cpu_pkg): LB=43, LBU=44, LH=45, LHU=46, LW=47, LWL=48, LWR=49, SB=50, SH=51, SW=52.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: start=1 → latch op/addr/store_data/rt_old → ACCESS (or DONE with addr_err if misaligned and check enabled).
  - ACCESS: read or write asserted; stay while waitrequest=1; on waitrequest=0 capture readdata → DONE.
  - DONE: done=1 for one cycle; accepts a new start (busy=0) → ACCESS, else → IDLE.
- Lane mapping, n=addr[1:0]: little-endian, byte n in lane n.
- Loads: LB/LBU pick lane n, sign/zero-extend; LH/LHU pick lanes {n+1,n}, sign/zero-extend; LW whole word.
- LWL: (mem << 8*(3-n)) | (rt_old & ((1<<8*(3-n))-1)). LWR: (mem >> 8*n) | (rt_old & ~(32'hFFFFFFFF >> 8*n)).
- Loads drive byteenable=4'b1111. Stores: SB byteenable=1<<n, data shifted into lane n, other lanes zero; SH byteenable=4'b0011<<n; SW 4'b1111.
- Illegal op on start: treated as no-op, done pulses next cycle, no bus transaction, load_data unchanged.

## Timing
- Reset values: busy=0, done=0, load_data=0, addr_err=0, read=0, write=0, address=0, byteenable=0, writedata=0; FSM=IDLE.
- start sampled at edge E0 → read/write high from cycle 1; with waitrequest=0 in cycle 1, done in cycle 2. Minimum latency 2 cycles; each waitrequest cycle adds 1.
- Back-to-back: start during done cycle → bus strobe the next cycle; throughput one op per 2 cycles.
- start while busy=1 ignored.
- Bus outputs stable for the whole stall; read and write never both high.
- reset during ACCESS: strobes drop at the next edge, no done, any captured data discarded.

## Configuration
- LSU_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0 → no bus access; done and addr_err pulse the cycle after start; load_data unchanged.
- Undefined: addr_err tied 0; misaligned halfword uses n&2, word uses n=0 (low bits ignored); access always performed.

## Structure
- cpu_pkg: opcode_internal enum (extended with the codes above) and the lsu_state_t typedef (IDLE/ACCESS/DONE).
- Sub-module lsu_extract: combinational extraction/extension and LWL/LWR merge (op, n, readdata, rt_old → load_data value). The FSM, latches and store lane steering stay in load_store_unit.

## Test plan
- LW 0x100, mem=0x44332211, waitrequest=0 → read high cycle 1, address 0x100, done cycle 2, load_data=0x44332211.
- mem 0x80FF7F01 at 0x100: LB 0x102 → 0xFFFFFFFF; LBU 0x102 → 0x000000FF; LH 0x102 → 0xFFFF80FF.
- LWL 0x101 / LWR 0x102, mem=0x44332211, rt_old=0xAABBCCDD → 0x2211CCDD / 0xAABB4433.
- SB 0x103, store_data=0x000000AB, waitrequest high 3 cycles → write held 4 cycles, byteenable=4'b1000, writedata=0xAB000000, done once.
- LW 0x102 with LSU_ALIGN_CHECK_EN → no read, done+addr_err in cycle 1; without macro → read at 0x100.
- Reset asserted mid-stall → read=0 next cycle, no done; new LW then completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: internal load/store opcodes, LSU state encoding and opcode classification helpers
package cpu_pkg;

    typedef enum logic [6:0] {
        OP_LB  = 7'd43,
        OP_LBU = 7'd44,
        OP_LH  = 7'd45,
        OP_LHU = 7'd46,
        OP_LW  = 7'd47,
        OP_LWL = 7'd48,
        OP_LWR = 7'd49,
        OP_SB  = 7'd50,
        OP_SH  = 7'd51,
        OP_SW  = 7'd52
    } opcode_internal;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t IDLE   = 2'd0;
    localparam lsu_state_t ACCESS = 2'd1;
    localparam lsu_state_t DONE   = 2'd2;

    function automatic logic is_load(input logic [6:0] op);
        return op >= OP_LB && op <= OP_LWR;
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return op >= OP_SB && op <= OP_SW;
    endfunction

    // Halfwords need an even address, words a word-aligned one; LWL/LWR and bytes never fault
    function automatic logic misaligned(input logic [6:0] op, input logic [1:0] n);
        return ((op == OP_LH || op == OP_LHU || op == OP_SH) && n[0]) ||
               ((op == OP_LW || op == OP_SW) && n != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_extract.sv
// lsu_extract: picks, extends or merges the load result from a little-endian bus word
module lsu_extract
    import cpu_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [1:0]  n,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sr;
    logic [4:0]  sl;

    // Halfwords use lane pair n&2 so an unchecked odd address still reads an aligned pair
    always_comb begin
        sr    = {n, 3'b000};
        sl    = {~n, 3'b000};
        b     = 8'(readdata >> sr);
        h     = 16'(readdata >> {n[1], 4'b0000});
        value = op == OP_LB  ? {{24{b[7]}}, b}
              : op == OP_LBU ? {24'h0, b}
              : op == OP_LH  ? {{16{h[15]}}, h}
              : op == OP_LHU ? {16'h0, h}
              : op == OP_LWL ? (readdata << sl) | (rt_old & ~(32'hFFFFFFFF << sl))
              : op == OP_LWR ? (readdata >> sr) | (rt_old & ~(32'hFFFFFFFF >> sr))
              : readdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one Avalon-MM access per load/store op; LSU_ALIGN_CHECK_EN enables misalignment faults
module load_store_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    lsu_state_t  state;
    logic [6:0]  op_q;
    logic [1:0]  n_q;
    logic [31:0] rt_q;
    logic [31:0] ext;
    logic [1:0]  n;
    logic        ld;
    logic        st;
    logic        misal;
    logic [3:0]  st_be;
    logic [31:0] st_wd;

    // Classify the request and steer store data into its byte lanes
    always_comb begin
        n     = addr[1:0];
        ld    = is_load(op);
        st    = is_store(op);
`ifdef LSU_ALIGN_CHECK_EN
        misal = misaligned(op, n);
`else
        misal = 1'b0;
`endif
        st_be = op == OP_SB ? 4'b0001 << n
              : op == OP_SH ? 4'b0011 << {n[1], 1'b0}
              : 4'b1111;
        st_wd = op == OP_SB ? {24'h0, store_data[7:0]} << {n, 3'b000}
              : op == OP_SH ? {16'h0, store_data[15:0]} << {n[1], 4'b0000}
              : store_data;
    end

    lsu_extract u_extract (
        .op       (op_q),
        .n        (n_q),
        .readdata (readdata),
        .rt_old   (rt_q),
        .value    (ext)
    );

    // FSM: bus outputs are registered and only change on accept or completion, so they hold through stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_err   <= 1'b0;
            load_data  <= 32'h0;
            address    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'h0;
            writedata  <= 32'h0;
            op_q       <= 7'h0;
            n_q        <= 2'h0;
            rt_q       <= 32'h0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            if (state == ACCESS) begin
                if (!waitrequest) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    read  <= 1'b0;
                    write <= 1'b0;
                    if (is_load(op_q))
                        load_data <= ext;
                end
            end else if (start) begin
                op_q <= op;
                n_q  <= n;
                rt_q <= rt_old;
                if ((ld || st) && !misal) begin
                    state      <= ACCESS;
                    busy       <= 1'b1;
                    read       <= ld;
                    write      <= st;
                    address    <= {addr[31:2], 2'b00};
                    byteenable <= ld ? 4'b1111 : st_be;
                    writedata  <= st ? st_wd : 32'h0;
                end else begin
                    state    <= DONE;
                    done     <= 1'b1;
                    addr_err <= misal;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test-plan cases plus a randomized run checked against a transaction-level model
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam logic [6:0] LB = 7'd43, LBU = 7'd44, LH = 7'd45, LHU = 7'd46, LW = 7'd47;
    localparam logic [6:0] LWL = 7'd48, LWR = 7'd49, SB = 7'd50, SH = 7'd51, SW = 7'd52;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        waitrequest = 1'b0;
    logic [6:0]  op = 7'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] rt_old = 32'h0;
    logic        busy, done, addr_err, read, write;
    logic [31:0] load_data, address, writedata, readdata;
    logic [3:0]  byteenable;
    logic [31:0] mem [16];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign readdata = mem[address[5:2]];

    load_store_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .addr        (addr),
        .store_data  (store_data),
        .rt_old      (rt_old),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .addr_err    (addr_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] o);
        return o >= LB && o <= SW;
    endfunction

    function automatic bit ref_misal(input logic [6:0] o, input logic [1:0] n);
        return ((o == LH || o == LHU || o == SH) && n[0]) || ((o == LW || o == SW) && n != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [6:0] o, input logic [1:0] n,
                                             input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  b [4];
        logic [15:0] hw;
        logic [63:0] t;
        int          nn;
        int          h;
        nn = int'(n);
        h = nn & 2;
        for (int i = 0; i < 4; i++) b[i] = m[8*i +: 8];
        hw = {b[h+1], b[h]};
        t = ({32'h0, m} << (8 * (3 - nn))) | ({32'h0, rt} & ((64'd1 << (8 * (3 - nn))) - 64'd1));
        case (o)
            LB:      return {{24{b[nn][7]}}, b[nn]};
            LBU:     return {24'h0, b[nn]};
            LH:      return {{16{hw[15]}}, hw};
            LHU:     return {16'h0, hw};
            LWL:     return t[31:0];
            LWR:     return (m >> (8 * nn)) | (rt & ~(32'hFFFFFFFF >> (8 * nn)));
            default: return m;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [6:0] o, input logic [1:0] n);
        int nn;
        nn = int'(n);
        return o == SB ? 4'(1 << nn) : o == SH ? 4'(3 << (nn & 2)) : 4'hF;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [6:0] o, input logic [1:0] n, input logic [31:0] sd);
        int nn;
        nn = int'(n);
        return o == SB ? {24'h0, sd[7:0]} << (8 * nn) : o == SH ? {16'h0, sd[15:0]} << (8 * (nn & 2)) : sd;
    endfunction

    // Transaction-level model: one op in flight, completion on the first non-stalled bus cycle
    logic        init = 1'b0, pend = 1'b0, m_ld = 1'b0, done_due = 1'b0, err_due = 1'b0, fresh = 1'b0;
    logic [6:0]  m_op = 7'h0;
    logic [1:0]  m_n = 2'h0;
    logic [31:0] m_rt = 32'h0, e_addr = 32'h0, e_wd = 32'h0, exp_ld = 32'h0;
    logic [3:0]  e_be = 4'h0;

    always @(posedge clk) begin
        if (reset) begin
            init = 1'b1; pend = 1'b0; done_due = 1'b0; err_due = 1'b0; fresh = 1'b1;
            exp_ld = 32'h0; e_addr = 32'h0; e_be = 4'h0; e_wd = 32'h0; m_ld = 1'b0;
        end else begin
            done_due = 1'b0;
            err_due = 1'b0;
            if (pend) begin
                if (!waitrequest) begin
                    pend = 1'b0;
                    done_due = 1'b1;
                    if (m_ld)
                        exp_ld = ref_load(m_op, m_n, mem[e_addr[5:2]], m_rt);
                    else
                        for (int i = 0; i < 4; i++)
                            if (e_be[i]) mem[e_addr[5:2]][8*i +: 8] = e_wd[8*i +: 8];
                end
            end else if (start) begin
                if (!legal(op)) begin
                    done_due = 1'b1;
                end else if (ALN && ref_misal(op, addr[1:0])) begin
                    done_due = 1'b1;
                    err_due = 1'b1;
                end else begin
                    pend = 1'b1; fresh = 1'b0;
                    m_ld = op <= LWR; m_op = op; m_n = addr[1:0]; m_rt = rt_old;
                    e_addr = {addr[31:2], 2'b00};
                    e_be = m_ld ? 4'hF : ref_be(op, addr[1:0]);
                    e_wd = ref_wd(op, addr[1:0], store_data);
                end
            end
        end
    end

    // Compare every cycle mid-period against the model
    always @(negedge clk) begin
        if (init) begin
            chk("busy", 32'(busy), 32'(pend));
            chk("done", 32'(done), 32'(done_due));
            chk("addr_err", 32'(addr_err), 32'(err_due));
            chk("read", 32'(read), 32'(pend && m_ld));
            chk("write", 32'(write), 32'(pend && !m_ld));
            chk("load_data", load_data, exp_ld);
            if (pend || fresh) begin
                chk("address", address, e_addr);
                chk("byteenable", 32'(byteenable), 32'(e_be));
                if (!m_ld) chk("writedata", writedata, e_wd);
            end
        end
    end

    int          rd_n, wr_n, lat;
    logic [31:0] a_seen, wd_seen;
    logic [3:0]  be_seen;
    logic        err_seen;

    task automatic run_op(input logic [6:0] o, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rt, input int nw);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
        rd_n = 0; wr_n = 0; lat = 0; err_seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            waitrequest = (k <= nw);
            @(negedge clk);
            if (read) begin rd_n++; a_seen = address; be_seen = byteenable; end
            if (write) begin wr_n++; a_seen = address; be_seen = byteenable; wd_seen = writedata; end
            if (done) begin got = 1'b1; lat = k; err_seen = addr_err; break; end
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_address", address, 32'h0);

        mem[0] = 32'h44332211;
        run_op(LW, 32'h100, 32'h0, 32'h0, 0);
        chk("lw_reads", 32'(rd_n), 32'd1);
        chk("lw_address", a_seen, 32'h100);
        chk("lw_latency", 32'(lat), 32'd2);
        chk("lw_data", load_data, 32'h44332211);

        mem[0] = 32'h80FF7F01;
        run_op(LB, 32'h102, 32'h0, 32'h0, 0);
        chk("lb_data", load_data, 32'hFFFFFFFF);
        run_op(LBU, 32'h102, 32'h0, 32'h0, 0);
        chk("lbu_data", load_data, 32'h000000FF);
        run_op(LH, 32'h102, 32'h0, 32'h0, 0);
        chk("lh_data", load_data, 32'hFFFF80FF);

        mem[0] = 32'h44332211;
        run_op(LWL, 32'h101, 32'h0, 32'hAABBCCDD, 0);
        chk("lwl_data", load_data, 32'h2211CCDD);
        run_op(LWR, 32'h102, 32'h0, 32'hAABBCCDD, 0);
        chk("lwr_data", load_data, 32'hAABB4433);

        run_op(SB, 32'h103, 32'h000000AB, 32'h0, 3);
        chk("sb_write_cycles", 32'(wr_n), 32'd4);
        chk("sb_byteenable", 32'(be_seen), 32'h8);
        chk("sb_writedata", wd_seen, 32'hAB000000);
        chk("sb_latency", 32'(lat), 32'd5);
        chk("sb_load_kept", load_data, 32'hAABB4433);
        @(negedge clk);
        chk("sb_done_once", 32'(done), 32'd0);

        run_op(LW, 32'h102, 32'h0, 32'h0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("mis_reads", 32'(rd_n), 32'd0);
        chk("mis_latency", 32'(lat), 32'd1);
        chk("mis_err", 32'(err_seen), 32'd1);
        chk("mis_load_kept", load_data, 32'hAABB4433);
`else
        chk("mis_reads", 32'(rd_n), 32'd1);
        chk("mis_address", a_seen, 32'h100);
        chk("mis_latency", 32'(lat), 32'd2);
        chk("mis_err", 32'(err_seen), 32'd0);
`endif

        @(posedge clk); #1;
        start = 1'b1; op = LW; addr = 32'h104; waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("stall_read", 32'(read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        chk("rst_read_drop", 32'(read), 32'd0);
        chk("rst_no_done", 32'(done), 32'd0);
        chk("rst_load_clear", load_data, 32'h0);
        run_op(LW, 32'h104, 32'h0, 32'h0, 0);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_data", load_data, mem[1]);

        repeat (3000) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'(43 + $urandom_range(0, 9));
            addr = 32'h100 + 32'($urandom_range(0, 63));
            store_data = $urandom;
            rt_old = $urandom;
            waitrequest = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0; waitrequest = 1'b0;
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
